stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- Push/pop engine for the Forth parameter stack and return stack.
- Takes the current PSP/RSP values from the register file and performs the stack memory access.
- Writes the updated pointer back through the register file write port: register 1 for PSP, register 2 for RSP.
- Sits between the control unit, which issues stack ops, and the data memory bus.

Parameters:
- PS_BASE, 48, first word of parameter stack region (empty PSP value)
- PS_LIMIT, 56, one past last parameter stack word (full PSP value)
- RS_BASE, 56, first word of return stack region (empty RSP value)
- RS_LIMIT, 64, one past last return stack word (full RSP value)

Ports:
- c_CLOCK  in  1  single system clock, all state on rising edge
- c_RESET_N  in  1  asynchronous active-low reset
- i_START  in  1  op request, accepted only when o_READY=1
- i_OP  in  2  00 PUSH, 01 POP, 10 PEEK, 11 DROP
- f_RSTACK  in  1  0 = parameter stack (PSP), 1 = return stack (RSP)
- i_DATA  in  16  value to push
- i_PSP  in  16  current PSP from register file
- i_RSP  in  16  current RSP from register file
- o_READY  out  1  unit idle, may accept i_START
- o_DONE  out  1  one-cycle completion pulse
- o_ERR  out  1  valid with o_DONE: overflow/underflow, op suppressed
- o_RDATA  out  16  popped/peeked value, valid with o_DONE
- o_MADDR  out  16  memory address
- o_MDATA  out  16  memory write data
- o_MWRITE  out  1  memory write request
- o_MREAD  out  1  memory read request
- i_MDATA  in  16  memory read data, valid when i_MREADY=1
- i_MREADY  in  1  memory completes current request this cycle
- o_WADDR  out  4  register file write address (1 or 2)
- o_WDATA  out  16  new pointer value
- o_WRITE  out  1  register file write strobe, one cycle

Behaviour:
- Reset (async, c_RESET_N=0):
  - FSM enters IDLE.
  - o_READY=1; all other outputs 0, including o_RDATA, o_MADDR, o_WADDR.
  - Reset mid-operation abandons the op with no write-back.
- States: IDLE, MEM, WB, DONE.
- IDLE, on i_START=1:
  - Latch i_OP, f_RSTACK and i_DATA.
  - Latch SP = i_RSP if f_RSTACK=1, else i_PSP.
  - BASE/LIMIT are selected by f_RSTACK.
  - i_START while o_READY=0 is ignored.
- Bounds check at accept:
  - PUSH with SP>=LIMIT is an overflow error.
  - POP, PEEK or DROP with SP<=BASE is an underflow error.
  - On error: go straight to DONE with o_ERR=1, no memory access, no write-back.
- Next state after accept (no error):
  - PUSH, POP, PEEK go to MEM.
  - DROP goes to WB.
- MEM:
  - PUSH: o_MWRITE=1, o_MADDR=SP, o_MDATA=data.
  - POP/PEEK: o_MREAD=1, o_MADDR=SP-1.
  - Request held stable until i_MREADY=1.
  - On ready, capture i_MDATA into o_RDATA (reads only).
  - PEEK then goes to DONE; others go to WB.
- WB (exactly one cycle):
  - o_WRITE=1, o_WADDR=2 if RSTACK else 1.
  - o_WDATA = SP+1 for PUSH, SP-1 for POP/DROP.
  - Arithmetic is 16-bit modulo; bounds checking makes wrap unreachable for legal parameters.
- DONE (one cycle):
  - o_DONE=1 and o_ERR valid.
  - o_RDATA holds until the next read completes.
  - Return to IDLE; o_READY=1 the following cycle.
- Latency with i_MREADY tied to 1 (START in cycle 0):
  - PUSH/POP: MEM in 1, WB in 2, DONE in 3.
  - PEEK: DONE in 2.
  - DROP: WB in 1, DONE in 2.
  - Error: DONE in 1.
- Pointer source:
  - The caller must not change i_PSP/i_RSP externally during an op.
  - The unit uses only the latched SP.
- o_MREAD and o_MWRITE are never both 1; o_WRITE never coincides with either.

Test Plan:
- PUSH 16'hBEEF with i_PSP=48, f_RSTACK=0, i_MREADY=1:
  - o_MWRITE cycle with o_MADDR=48, o_MDATA=BEEF.
  - Then o_WRITE with o_WADDR=1, o_WDATA=49.
  - o_DONE at cycle 3, o_ERR=0.
- POP with f_RSTACK=1, i_RSP=58, memory returns 16'h1234 after 3 wait cycles:
  - o_MREAD with o_MADDR=57 held for 4 cycles.
  - o_WADDR=2, o_WDATA=57; o_RDATA=1234 at o_DONE.
- PEEK with i_PSP=50 returning 16'h00AA:
  - o_MADDR=49, o_RDATA=00AA.
  - No o_WRITE; o_DONE at cycle 2.
- Bounds errors, each gives o_DONE with o_ERR=1 at cycle 1 and no o_MWRITE/o_MREAD/o_WRITE:
  - PUSH with i_PSP=56.
  - POP with i_RSP=56.
- DROP with i_PSP=52:
  - o_WRITE with o_WADDR=1, o_WDATA=51 at cycle 1; no memory request.
  - A second i_START during the op is ignored.
- Assert c_RESET_N=0 during a MEM wait:
  - Outputs immediately 0 and o_READY=1.
  - No write-back after release; next PUSH behaves normally.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit: push/pop engine for the Forth parameter and return stacks.
// Accepts one stack op at a time, checks bounds against the selected
// region, performs the single memory access and writes the updated
// pointer back to register 1 (PSP) or register 2 (RSP).
//
// Handshakes: i_START is sampled only while o_READY=1, which is asserted
// only in IDLE, so an op is accepted exactly on a cycle with
// i_START && o_READY. A memory request (o_MREAD/o_MWRITE with o_MADDR and
// o_MDATA) is held stable until the cycle in which i_MREADY=1; that cycle
// completes it. o_DONE is a one-cycle pulse and needs no acknowledgement.
module stack_unit #(
    parameter logic [15:0] PS_BASE  = 16'd48,
    parameter logic [15:0] PS_LIMIT = 16'd56,
    parameter logic [15:0] RS_BASE  = 16'd56,
    parameter logic [15:0] RS_LIMIT = 16'd64
) (
    input  logic        c_CLOCK,
    input  logic        c_RESET_N,
    input  logic        i_START,
    input  logic [1:0]  i_OP,
    input  logic        f_RSTACK,
    input  logic [15:0] i_DATA,
    input  logic [15:0] i_PSP,
    input  logic [15:0] i_RSP,
    output logic        o_READY,
    output logic        o_DONE,
    output logic        o_ERR,
    output logic [15:0] o_RDATA,
    output logic [15:0] o_MADDR,
    output logic [15:0] o_MDATA,
    output logic        o_MWRITE,
    output logic        o_MREAD,
    input  logic [15:0] i_MDATA,
    input  logic        i_MREADY,
    output logic [3:0]  o_WADDR,
    output logic [15:0] o_WDATA,
    output logic        o_WRITE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_PEEK = 2'b10,
        OP_DROP = 2'b11
    } op_e;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic        rstack_q, rstack_d;
    logic [15:0] data_q, data_d;
    logic [15:0] sp_q, sp_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;

    // Region selected by the incoming request, used only at accept time
    logic [15:0] sel_sp, sel_base, sel_limit;
    logic        sel_err;

    assign sel_sp    = f_RSTACK ? i_RSP : i_PSP;
    assign sel_base  = f_RSTACK ? RS_BASE : PS_BASE;
    assign sel_limit = f_RSTACK ? RS_LIMIT : PS_LIMIT;
    assign sel_err   = (op_e'(i_OP) == OP_PUSH) ? (sel_sp >= sel_limit)
                                                : (sel_sp <= sel_base);

    // State and operand registers; reset abandons any op in flight
    always_ff @(posedge c_CLOCK or negedge c_RESET_N) begin
        if (!c_RESET_N) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_PUSH;
            rstack_q <= 1'b0;
            data_q   <= 16'd0;
            sp_q     <= 16'd0;
            err_q    <= 1'b0;
            rdata_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rstack_q <= rstack_d;
            data_q   <= data_d;
            sp_q     <= sp_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rstack_d = rstack_q;
        data_d   = data_q;
        sp_d     = sp_q;
        err_d    = err_q;
        rdata_d  = rdata_q;

        o_READY  = 1'b0;
        o_DONE   = 1'b0;
        o_ERR    = 1'b0;
        o_MADDR  = 16'd0;
        o_MDATA  = 16'd0;
        o_MWRITE = 1'b0;
        o_MREAD  = 1'b0;
        o_WADDR  = 4'd0;
        o_WDATA  = 16'd0;
        o_WRITE  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_READY = 1'b1;
                if (i_START) begin
                    op_d     = op_e'(i_OP);
                    rstack_d = f_RSTACK;
                    data_d   = i_DATA;
                    sp_d     = sel_sp;
                    err_d    = sel_err;
                    if (sel_err) begin
                        state_d = ST_DONE;
                    end else if (op_e'(i_OP) == OP_DROP) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_MEM;
                    end
                end
            end
            ST_MEM: begin
                if (op_q == OP_PUSH) begin
                    o_MWRITE = 1'b1;
                    o_MADDR  = sp_q;
                    o_MDATA  = data_q;
                end else begin
                    // POP and PEEK read the top element, one below SP
                    o_MREAD = 1'b1;
                    o_MADDR = sp_q - 16'd1;
                end
                if (i_MREADY) begin
                    if (op_q != OP_PUSH) begin
                        rdata_d = i_MDATA;
                    end
                    state_d = (op_q == OP_PEEK) ? ST_DONE : ST_WB;
                end
            end
            ST_WB: begin
                o_WRITE = 1'b1;
                o_WADDR = rstack_q ? 4'd2 : 4'd1;
                o_WDATA = (op_q == OP_PUSH) ? (sp_q + 16'd1) : (sp_q - 16'd1);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                o_DONE  = 1'b1;
                o_ERR   = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_RDATA = rdata_q;

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed cycle-accurate checks of stack_unit.
module tb_stack_unit;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [1:0]  i_op;
    logic        f_rstack;
    logic [15:0] i_data;
    logic [15:0] i_psp;
    logic [15:0] i_rsp;
    logic        o_ready;
    logic        o_done;
    logic        o_err;
    logic [15:0] o_rdata;
    logic [15:0] o_maddr;
    logic [15:0] o_mdata;
    logic        o_mwrite;
    logic        o_mread;
    logic [15:0] i_mdata;
    logic        i_mready;
    logic [3:0]  o_waddr;
    logic [15:0] o_wdata;
    logic        o_write;

    int total;
    int bad;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;
    localparam logic [1:0] OP_DROP = 2'b11;

    stack_unit dut (
        .c_CLOCK   (clk),
        .c_RESET_N (rst_n),
        .i_START   (i_start),
        .i_OP      (i_op),
        .f_RSTACK  (f_rstack),
        .i_DATA    (i_data),
        .i_PSP     (i_psp),
        .i_RSP     (i_rsp),
        .o_READY   (o_ready),
        .o_DONE    (o_done),
        .o_ERR     (o_err),
        .o_RDATA   (o_rdata),
        .o_MADDR   (o_maddr),
        .o_MDATA   (o_mdata),
        .o_MWRITE  (o_mwrite),
        .o_MREAD   (o_mread),
        .i_MDATA   (i_mdata),
        .i_MREADY  (i_mready),
        .o_WADDR   (o_waddr),
        .o_WDATA   (o_wdata),
        .o_WRITE   (o_write)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns 1ns into cycle 1
    task automatic start_op(input logic [1:0] op, input logic rs, input logic [15:0] data,
                            input logic [15:0] psp, input logic [15:0] rsp);
        @(negedge clk);
        i_op     = op;
        f_rstack = rs;
        i_data   = data;
        i_psp    = psp;
        i_rsp    = rsp;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
    endtask

    // Idle bus: nothing requested, nothing written
    task automatic check_quiet(input string tag);
        check({tag, ".mwrite"}, {15'd0, o_mwrite}, 16'd0);
        check({tag, ".mread"},  {15'd0, o_mread},  16'd0);
        check({tag, ".write"},  {15'd0, o_write},  16'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        i_start  = 1'b0;
        i_op     = 2'b00;
        f_rstack = 1'b0;
        i_data   = 16'd0;
        i_psp    = 16'd48;
        i_rsp    = 16'd56;
        i_mdata  = 16'd0;
        i_mready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst.ready", {15'd0, o_ready}, 16'd1);
        check("rst.done",  {15'd0, o_done},  16'd0);
        check("rst.err",   {15'd0, o_err},   16'd0);
        check("rst.rdata", o_rdata, 16'd0);
        check("rst.maddr", o_maddr, 16'd0);
        check("rst.waddr", {12'd0, o_waddr}, 16'd0);
        check_quiet("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // PUSH BEEF onto empty parameter stack
        start_op(OP_PUSH, 1'b0, 16'hBEEF, 16'd48, 16'd56);
        check("push.c1.mwrite", {15'd0, o_mwrite}, 16'd1);
        check("push.c1.mread",  {15'd0, o_mread},  16'd0);
        check("push.c1.maddr",  o_maddr, 16'd48);
        check("push.c1.mdata",  o_mdata, 16'hBEEF);
        check("push.c1.ready",  {15'd0, o_ready},  16'd0);
        tick();
        check("push.c2.write",  {15'd0, o_write},  16'd1);
        check("push.c2.waddr",  {12'd0, o_waddr},  16'd1);
        check("push.c2.wdata",  o_wdata, 16'd49);
        check("push.c2.mwrite", {15'd0, o_mwrite}, 16'd0);
        tick();
        check("push.c3.done",   {15'd0, o_done},   16'd1);
        check("push.c3.err",    {15'd0, o_err},    16'd0);
        tick();
        check("push.c4.ready",  {15'd0, o_ready},  16'd1);
        check("push.c4.done",   {15'd0, o_done},   16'd0);

        // POP from return stack with three memory wait cycles
        i_mready = 1'b0;
        start_op(OP_POP, 1'b1, 16'h0000, 16'd48, 16'd58);
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("pop.c%0d.mread", c), {15'd0, o_mread}, 16'd1);
            check($sformatf("pop.c%0d.maddr", c), o_maddr, 16'd57);
            check($sformatf("pop.c%0d.write", c), {15'd0, o_write}, 16'd0);
            tick();
        end
        i_mready = 1'b1;
        i_mdata  = 16'h1234;
        check("pop.c4.mread", {15'd0, o_mread}, 16'd1);
        check("pop.c4.maddr", o_maddr, 16'd57);
        tick();
        i_mdata  = 16'hDEAD;
        check("pop.c5.write", {15'd0, o_write}, 16'd1);
        check("pop.c5.waddr", {12'd0, o_waddr}, 16'd2);
        check("pop.c5.wdata", o_wdata, 16'd57);
        check("pop.c5.mread", {15'd0, o_mread}, 16'd0);
        tick();
        check("pop.c6.done",  {15'd0, o_done}, 16'd1);
        check("pop.c6.err",   {15'd0, o_err},  16'd0);
        check("pop.c6.rdata", o_rdata, 16'h1234);
        tick();

        // PEEK parameter stack top
        i_mdata = 16'h00AA;
        start_op(OP_PEEK, 1'b0, 16'h0000, 16'd50, 16'd56);
        check("peek.c1.mread", {15'd0, o_mread}, 16'd1);
        check("peek.c1.maddr", o_maddr, 16'd49);
        check("peek.c1.write", {15'd0, o_write}, 16'd0);
        tick();
        i_mdata = 16'h0000;
        check("peek.c2.done",  {15'd0, o_done}, 16'd1);
        check("peek.c2.rdata", o_rdata, 16'h00AA);
        check("peek.c2.write", {15'd0, o_write}, 16'd0);
        tick();
        check("peek.c3.rdata_hold", o_rdata, 16'h00AA);

        // PUSH overflow on full parameter stack
        start_op(OP_PUSH, 1'b0, 16'h7777, 16'd56, 16'd56);
        check("ovf.c1.done", {15'd0, o_done}, 16'd1);
        check("ovf.c1.err",  {15'd0, o_err},  16'd1);
        check_quiet("ovf.c1");
        tick();
        check("ovf.c2.ready", {15'd0, o_ready}, 16'd1);
        check_quiet("ovf.c2");

        // POP underflow on empty return stack
        start_op(OP_POP, 1'b1, 16'h0000, 16'd48, 16'd56);
        check("unf.c1.done", {15'd0, o_done}, 16'd1);
        check("unf.c1.err",  {15'd0, o_err},  16'd1);
        check_quiet("unf.c1");
        tick();

        // PEEK underflow on empty parameter stack
        start_op(OP_PEEK, 1'b0, 16'h0000, 16'd48, 16'd56);
        check("unf2.c1.err", {15'd0, o_err}, 16'd1);
        check_quiet("unf2.c1");
        tick();

        // Boundary: last free slot is a legal PUSH
        start_op(OP_PUSH, 1'b0, 16'h0055, 16'd55, 16'd56);
        check("edge.c1.mwrite", {15'd0, o_mwrite}, 16'd1);
        check("edge.c1.maddr",  o_maddr, 16'd55);
        tick();
        check("edge.c2.wdata",  o_wdata, 16'd56);
        tick();
        check("edge.c3.err",    {15'd0, o_err}, 16'd0);
        tick();

        // DROP, with a second START presented mid-op
        start_op(OP_DROP, 1'b0, 16'h0000, 16'd52, 16'd56);
        check("drop.c1.write", {15'd0, o_write}, 16'd1);
        check("drop.c1.waddr", {12'd0, o_waddr}, 16'd1);
        check("drop.c1.wdata", o_wdata, 16'd51);
        check("drop.c1.mwrite", {15'd0, o_mwrite}, 16'd0);
        check("drop.c1.mread",  {15'd0, o_mread},  16'd0);
        i_start = 1'b1;
        i_op    = OP_PUSH;
        i_psp   = 16'd48;
        tick();
        i_start = 1'b0;
        check("drop.c2.done", {15'd0, o_done}, 16'd1);
        check("drop.c2.err",  {15'd0, o_err},  16'd0);
        check_quiet("drop.c2");
        tick();
        check("drop.c3.ready", {15'd0, o_ready}, 16'd1);
        check_quiet("drop.c3");
        tick();
        check_quiet("drop.c4");

        // Reset during a stalled memory write
        i_mready = 1'b0;
        start_op(OP_PUSH, 1'b0, 16'h4444, 16'd50, 16'd56);
        check("rmid.c1.mwrite", {15'd0, o_mwrite}, 16'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rmid.ready", {15'd0, o_ready}, 16'd1);
        check("rmid.maddr", o_maddr, 16'd0);
        check("rmid.mdata", o_mdata, 16'd0);
        check("rmid.rdata", o_rdata, 16'd0);
        check_quiet("rmid.async");
        @(negedge clk);
        rst_n    = 1'b1;
        i_mready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_quiet($sformatf("rmid.post%0d", c));
            check($sformatf("rmid.post%0d.done", c), {15'd0, o_done}, 16'd0);
        end

        // Normal PUSH after reset recovery
        start_op(OP_PUSH, 1'b0, 16'h5555, 16'd50, 16'd56);
        check("rec.c1.maddr", o_maddr, 16'd50);
        check("rec.c1.mdata", o_mdata, 16'h5555);
        tick();
        check("rec.c2.wdata", o_wdata, 16'd51);
        tick();
        check("rec.c3.done",  {15'd0, o_done}, 16'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
